// File: rtl/sm_addsub_pipe.sv
// sm_addsub_pipe -- two-stage elastic, multi-lane sign-magnitude add/subtract.
//
// Each W-bit lane is sign-magnitude: bit W-1 is the sign, bits W-2:0 the
// magnitude. All lanes share one valid/ready handshake on each side.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   op[LANES]           per lane: 0 = a+b, 1 = a-b
//   sat                 1 = clamp magnitude on overflow, 0 = wrap
//   a, b                operands, lane i at [i*W +: W]
//   out_valid/out_ready output handshake
//   c                   results, same packing as a
//   zero, neg, overflow, cout   per-lane flags
module sm_addsub_pipe #(
  parameter int W     = 16,
  parameter int LANES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES-1:0]   op,
  input  logic               sat,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] c,
  output logic [LANES-1:0]   zero,
  output logic [LANES-1:0]   neg,
  output logic [LANES-1:0]   overflow,
  output logic [LANES-1:0]   cout
);

  localparam int MW = W - 1;

  logic                        s1_valid_q;
  logic                        s2_valid_q;
  logic                        s1_ready_s;

  logic [LANES-1:0]            s1_sa_d, s1_sa_q;
  logic [LANES-1:0]            s1_sb_d, s1_sb_q;
  logic [LANES-1:0]            s1_ge_d, s1_ge_q;
  logic [LANES-1:0][MW-1:0]    s1_ma_d, s1_ma_q;
  logic [LANES-1:0][MW-1:0]    s1_mb_d, s1_mb_q;
  logic                        s1_sat_q;

  logic [LANES-1:0][MW:0]      sum_s;
  logic [LANES-1:0][MW-1:0]    mag_s;
  logic [LANES-1:0]            sign_s;
  logic [LANES*W-1:0]          c_d, c_q;
  logic [LANES-1:0]            zero_d, zero_q;
  logic [LANES-1:0]            neg_d, neg_q;
  logic [LANES-1:0]            ovf_d, ovf_q;
  logic [LANES-1:0]            cout_d, cout_q;

  // Elastic handshake: a stage may load when it is empty or its content leaves.
  assign s1_ready_s = ~s2_valid_q | out_ready;
  assign in_ready   = ~s1_valid_q | s1_ready_s;

  // Operand decode: split sign/magnitude, fold -0 into +0, apply op to b's sign.
  always_comb begin
    s1_sa_d = '0;
    s1_sb_d = '0;
    s1_ge_d = '0;
    s1_ma_d = '0;
    s1_mb_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_ma_d[i] = a[i*W +: MW];
      s1_mb_d[i] = b[i*W +: MW];
      s1_sa_d[i] = a[i*W + MW] & (|a[i*W +: MW]);
      s1_sb_d[i] = (b[i*W + MW] & (|b[i*W +: MW])) ^ op[i];
      s1_ge_d[i] = (a[i*W +: MW] >= b[i*W +: MW]);
    end
  end

  // Lane arithmetic on stage-1 contents; result sign is cleared for a zero magnitude.
  always_comb begin
    sum_s  = '0;
    mag_s  = '0;
    sign_s = '0;
    c_d    = '0;
    zero_d = '0;
    neg_d  = '0;
    ovf_d  = '0;
    cout_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_s[i] = {1'b0, s1_ma_q[i]} + {1'b0, s1_mb_q[i]};
      if (s1_sa_q[i] == s1_sb_q[i]) begin
        sign_s[i] = s1_sa_q[i];
        ovf_d[i]  = sum_s[i][MW];
        cout_d[i] = sum_s[i][MW];
        if (sum_s[i][MW] & s1_sat_q) begin
          mag_s[i] = {MW{1'b1}};
        end else begin
          mag_s[i] = sum_s[i][MW-1:0];
        end
      end else if (s1_ge_q[i]) begin
        sign_s[i] = s1_sa_q[i];
        mag_s[i]  = s1_ma_q[i] - s1_mb_q[i];
        ovf_d[i]  = 1'b0;
        cout_d[i] = 1'b0;
      end else begin
        sign_s[i] = s1_sb_q[i];
        mag_s[i]  = s1_mb_q[i] - s1_ma_q[i];
        ovf_d[i]  = 1'b0;
        cout_d[i] = 1'b1;
      end
      zero_d[i]        = (mag_s[i] == {MW{1'b0}});
      neg_d[i]         = sign_s[i] & ~zero_d[i];
      c_d[i*W +: W]    = {neg_d[i], mag_s[i]};
    end
  end

  // Stage 1 register: captures decoded operands on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sa_q    <= '0;
      s1_sb_q    <= '0;
      s1_ge_q    <= '0;
      s1_ma_q    <= '0;
      s1_mb_q    <= '0;
      s1_sat_q   <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sa_q  <= s1_sa_d;
        s1_sb_q  <= s1_sb_d;
        s1_ge_q  <= s1_ge_d;
        s1_ma_q  <= s1_ma_d;
        s1_mb_q  <= s1_mb_d;
        s1_sat_q <= sat;
      end else begin
        s1_sat_q <= s1_sat_q;
      end
    end else begin
      s1_valid_q <= s1_valid_q;
    end
  end

  // Stage 2 register: holds result and flags stable until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      c_q        <= '0;
      zero_q     <= '0;
      neg_q      <= '0;
      ovf_q      <= '0;
      cout_q     <= '0;
    end else if (s1_ready_s) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        c_q    <= c_d;
        zero_q <= zero_d;
        neg_q  <= neg_d;
        ovf_q  <= ovf_d;
        cout_q <= cout_d;
      end else begin
        c_q <= c_q;
      end
    end else begin
      s2_valid_q <= s2_valid_q;
    end
  end

  assign out_valid = s2_valid_q;
  assign c         = c_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign overflow  = ovf_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Self-checking bench for sm_addsub_pipe: directed cases plus randomized
// streams compared against an integer-arithmetic reference model.
module tb_sm_addsub_pipe;

  localparam int W  = 16;
  localparam int L  = 2;
  localparam int VW = L*W + 4*L;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [L-1:0]   op;
  logic           sat;
  logic [L*W-1:0] a;
  logic [L*W-1:0] b;
  logic           out_valid;
  logic           out_ready;
  logic [L*W-1:0] c;
  logic [L-1:0]   zero;
  logic [L-1:0]   neg;
  logic [L-1:0]   overflow;
  logic [L-1:0]   cout;

  sm_addsub_pipe #(.W(W), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sat(sat), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .c(c), .zero(zero), .neg(neg),
    .overflow(overflow), .cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [VW-1:0] v; int cyc; } exp_t;
  exp_t            exp_q[$];
  logic [L*W-1:0]  src_a[$];
  logic [L*W-1:0]  src_b[$];
  logic [L-1:0]    src_op[$];
  logic            src_sat[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cnt_out  = 0;
  int acc_cnt  = 0;
  bit chk_lat  = 1'b1;
  bit rand_rdy = 1'b0;
  bit have_prev = 1'b0;
  logic [VW-1:0] prev_obs;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: treat each lane as a signed integer, add, then map back to sign-magnitude.
  function automatic logic [VW-1:0] model(input logic [L*W-1:0] av, input logic [L*W-1:0] bv,
                                          input logic [L-1:0] opv, input logic satv);
    logic [L*W-1:0] rc;
    logic [L-1:0]   rz, rn, ro, rco;
    int mx, ma, mb, va, vb, r, ar, mag;
    bit ovf;
    mx = (1 << (W-1)) - 1;
    rc = '0; rz = '0; rn = '0; ro = '0; rco = '0;
    for (int i = 0; i < L; i++) begin
      ma = int'(av[i*W +: W-1]);
      mb = int'(bv[i*W +: W-1]);
      va = av[i*W+W-1] ? -ma : ma;
      vb = bv[i*W+W-1] ? -mb : mb;
      if (opv[i]) vb = -vb;
      r  = va + vb;
      ar = (r < 0) ? -r : r;
      if ((va < 0) == (vb < 0)) begin
        ovf    = (ar > mx);
        rco[i] = ovf;
      end else begin
        ovf    = 1'b0;
        rco[i] = (ma < mb);
      end
      if (ovf) mag = satv ? mx : (ar % (mx + 1));
      else     mag = ar;
      ro[i] = ovf;
      rz[i] = (mag == 0);
      rn[i] = (mag != 0) && (r < 0);
      rc[i*W +: W] = {rn[i], mag[W-2:0]};
    end
    return {rc, rz, rn, ro, rco};
  endfunction

  function automatic logic [W-1:0] rnd_lane();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Output monitor: scoreboard on transfers, stability while stalled, model push on input transfers.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      logic [VW-1:0] obs;
      cyc++;
      obs = {c, zero, neg, overflow, cout};
      if (out_valid && out_ready) begin
        cnt_out++;
        have_prev = 1'b0;
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("result", 64'(obs), 64'(e.v));
          if (chk_lat) check_eq("latency", 64'(cyc - e.cyc), 64'd2);
        end
      end else if (out_valid) begin
        if (have_prev) check_eq("stall_hold", 64'(obs), 64'(prev_obs));
        prev_obs  = obs;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
      if (in_valid && in_ready) begin
        e.v   = model(a, b, op, sat);
        e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  task automatic push_set(input logic [L*W-1:0] av, input logic [L*W-1:0] bv,
                          input logic [L-1:0] opv, input logic satv);
    src_a.push_back(av); src_b.push_back(bv); src_op.push_back(opv); src_sat.push_back(satv);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++)
      push_set({rnd_lane(), rnd_lane()}, {rnd_lane(), rnd_lane()},
               L'($urandom), 1'($urandom));
  endtask

  task automatic load_next();
    if (src_a.size() > 0) begin
      a = src_a.pop_front(); b = src_b.pop_front();
      op = src_op.pop_front(); sat = src_sat.pop_front();
      in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic step();
    bit acc;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 2) != 0);
    if (acc) begin
      acc_cnt++;
      load_next();
    end
  endtask

  task automatic send_all(output int steps);
    steps = 0;
    if (!in_valid) load_next();
    while ((in_valid || src_a.size() > 0) && steps < 500) begin
      step();
      steps++;
    end
    if (steps >= 500) check_eq("send_timeout", 64'(steps), 64'd0);
  endtask

  task automatic expect_out(input string tag, input logic [VW-1:0] ev);
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    check_eq({tag, "_valid"}, 64'(found), 64'd1);
    if (found) check_eq(tag, 64'({c, zero, neg, overflow, cout}), 64'(ev));
  endtask

  initial begin
    int steps, base;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; sat = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    #12;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_outputs", 64'({c, zero, neg, overflow, cout}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Mixed-sign add and a subtract that swaps.
    push_set({16'h0003, 16'h0005}, {16'h0005, 16'h8003}, 2'b10, 1'b0);
    send_all(steps);
    expect_out("t1", {32'h8002_0002, 2'b00, 2'b10, 2'b00, 2'b10});

    // Zero results, including -0 input.
    push_set({16'h8000, 16'h8007}, {16'h0000, 16'h8007}, 2'b01, 1'b0);
    send_all(steps);
    expect_out("t2", {32'h0000_0000, 2'b11, 2'b00, 2'b00, 2'b00});

    // Overflow wrap, then saturate.
    push_set({16'hFFFF, 16'h7FFF}, {16'h8001, 16'h0001}, 2'b00, 1'b0);
    send_all(steps);
    expect_out("t3_wrap", {32'h0000_0000, 2'b11, 2'b00, 2'b11, 2'b11});
    push_set({16'hFFFF, 16'h7FFF}, {16'h8001, 16'h0001}, 2'b00, 1'b1);
    send_all(steps);
    expect_out("t3_sat", {32'hFFFF_7FFF, 2'b00, 2'b10, 2'b11, 2'b11});
    repeat (3) step();

    // Backpressure: only two sets fit while the output is blocked.
    chk_lat = 1'b0;
    out_ready = 1'b0;
    base = acc_cnt;
    push_random(4);
    load_next();
    repeat (5) step();
    check_eq("bp_accepted", 64'(acc_cnt - base), 64'd2);
    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    base = cnt_out;
    out_ready = 1'b1;
    repeat (4) step();
    check_eq("bp_drain_consecutive", 64'(cnt_out - base), 64'd4);
    repeat (2) step();
    chk_lat = 1'b1;

    // Full-rate streaming.
    base = cnt_out;
    push_random(16);
    send_all(steps);
    check_eq("stream_rate", 64'(steps), 64'd16);
    repeat (3) step();
    check_eq("stream_count", 64'(cnt_out - base), 64'd16);

    // Random backpressure stream.
    chk_lat = 1'b0;
    rand_rdy = 1'b1;
    push_random(40);
    send_all(steps);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check_eq("rand_drained", 64'(exp_q.size()), 64'd0);
    chk_lat = 1'b1;

    // Reset with both stages occupied.
    out_ready = 1'b0;
    push_random(2);
    send_all(steps);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_c", 64'(c), 64'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    #1 check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    base = cnt_out;
    repeat (5) step();
    check_eq("no_stale_out", 64'(cnt_out - base), 64'd0);

    // Fresh traffic after reset still works.
    push_random(6);
    send_all(steps);
    repeat (3) step();
    check_eq("final_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_addsub_pipe.md
Name: sm_addsub_pipe

Overview:
Pipelined, multi-lane sign-magnitude add/subtract unit for the vector datapath. Each lane holds a W-bit sign-magnitude value: bit W-1 is the sign, bits W-2:0 are the magnitude. All lanes share one valid/ready handshake. Each lane produces a result plus zero/neg/overflow/cout flags. Per-lane runtime add/sub selection and optional saturation are supported.

Parameters:
W, 16, lane width in bits (sign + W-1 magnitude bits); minimum 4
LANES, 2, number of independent lanes packed into the a/b/c buses

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  unit can accept an operand set this cycle
op  input  LANES  per lane: 0 = a+b, 1 = a-b
sat  input  1  1 = saturate magnitude on overflow; 0 = wrap
a  input  LANES*W  operand A; lane i at bits [i*W +: W]
b  input  LANES*W  operand B; same packing as a
out_valid  output  1  result set valid
out_ready  input  1  consumer accepts result this cycle
c  output  LANES*W  results, packed as a
zero  output  LANES  per lane: result magnitude == 0
neg  output  LANES  per lane: result sign bit
overflow  output  LANES  per lane: magnitude overflow occurred
cout  output  LANES  per lane: carry (same-sign) or swap/borrow (different-sign)

Behaviour:
- Reset (rst_n low, async): s1_valid = s2_valid = 0; c, zero, neg, overflow, cout = 0; out_valid = 0.
- in_ready is combinational from pipeline state and is 1 whenever reset is deasserted and the pipeline is empty.
- Two-stage elastic pipeline.
  - Stage 1 registers, per lane: effective sign of b (sb = b[W-1] ^ op[i]), magnitudes, comparison |a|>=|b|, and sat.
  - Stage 2 registers the result and flags.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - s1_ready = ~s2_valid | out_ready; in_ready = ~s1_valid | s1_ready.
  - Throughput is 1 set per cycle; latency is exactly 2 cycles from input transfer to out_valid.
- Stall: while out_valid & ~out_ready, c and all flags stay stable; no operand set is dropped or duplicated; order is preserved.
- Negative zero input (sign 1, magnitude 0) is treated as +0.
- Per-lane arithmetic, with ma/mb the (W-1)-bit magnitudes:
  - Same effective sign: m = ma + mb (W bits). cout = m[W-1]; overflow = m[W-1]; sign = sa.
  - Different sign, ma >= mb: magnitude = ma - mb; sign = sa; cout = 0; overflow = 0.
  - Different sign, ma < mb: magnitude = mb - ma; sign = sb; cout = 1; overflow = 0.
  - Overflow with sat=0: magnitude = m[W-2:0] (wraps).
  - Overflow with sat=1: magnitude = all ones (W-1 bits).
  - A zero result magnitude always forces sign = 0 (no -0 output).
  - zero = (result magnitude == 0); neg = result sign.
- Lanes are fully independent. No carry or flag crosses a lane boundary.
- Simultaneous in and out transfer with a full pipeline: both occur and occupancy is unchanged.
- Reset mid-operation flushes all in-flight sets. No result is emitted for any set accepted before reset.

Test Plan:
1. W=16, LANES=2. Lane0 a=0x0005, b=0x8003, op=0; lane1 a=0x0003, b=0x0005, op=1; one transfer -> 2 cycles later out_valid=1. Lane0 c=0x0002, flags zero=0/neg=0/ovf=0/cout=0. Lane1 c=0x8002, neg=1, cout=1.
2. Lane0 a=0x8007 minus b=0x8007 -> c=0x0000, zero=1, neg=0. Lane1 a=0x8000 plus b=0x0000 -> c=0x0000, zero=1, neg=0.
3. Lane0 a=0x7FFF plus b=0x0001, sat=0 -> c=0x0000, overflow=1, zero=1, cout=1. Same operands with sat=1 -> c=0x7FFF, overflow=1, zero=0. Lane1 a=0xFFFF plus b=0x8001, sat=1 -> c=0xFFFF, neg=1, overflow=1.
4. Backpressure: hold out_ready=0 and offer 4 back-to-back sets -> 2 sets accepted, then in_ready=0. c is held constant while stalled. Then set out_ready=1 -> the 4 results appear in order on consecutive cycles, none lost.
5. Streaming: in_valid=1 and out_ready=1 for 16 cycles with random operands -> 16 results at 1 per cycle, each 2 cycles after its input; all match the scoreboard.
6. Reset: assert rst_n=0 with both stages full -> out_valid=0 and c=0 without waiting for a clock edge. After release, in_ready=1 and no stale result is emitted.
